// File: rtl/bcd_pkg.sv
// Shared definitions for the decimal arithmetic datapath: digit width,
// largest legal BCD digit, subtractor FSM states and a digit-legality helper.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    CMP
  } state_t;

  function automatic logic digit_valid(input logic [BCD_W-1:0] dig);
    return dig <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtractor: d = x - y - bin.
// A negative result is folded back into the range 0..9 and reported as a borrow.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] x,
  input  logic [BCD_W-1:0] y,
  input  logic             bin,
  output logic [BCD_W-1:0] d,
  output logic             bout
);

  logic signed [BCD_W:0] t;

  // The range is -10..9, so five signed bits hold it; the +10 wraps modulo 16.
  always_comb begin
    t    = signed'({1'b0, x}) - signed'({1'b0, y}) - signed'({{BCD_W{1'b0}}, bin});
    bout = t[BCD_W];
    d    = bout ? (t[BCD_W-1:0] + BCD_W'(10)) : t[BCD_W-1:0];
  end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor returning |a-b| and a sign flag.
// When the first pass borrows out, a ten's-complement pass turns the result into a magnitude.
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*NDIG-1:0]     a,
  input  logic [4*NDIG-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [4*NDIG-1:0]     diff,
  output logic                  neg,
  output logic                  invalid
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  state_t                state_q, state_d;
  logic [4*NDIG-1:0]     a_q, a_d;
  logic [4*NDIG-1:0]     b_q, b_d;
  logic [4*NDIG-1:0]     diff_q, diff_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  borrow_q, borrow_d;
  logic                  neg_q, neg_d;
  logic                  invalid_q, invalid_d;
  logic                  done_q, done_d;

  logic                  ops_valid;
  logic [BCD_W-1:0]      sub_x, sub_y, sub_d;
  logic                  sub_bout;
  logic                  last;

  always_comb begin
    ops_valid = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (!digit_valid(a_q[i*BCD_W +: BCD_W]) || !digit_valid(b_q[i*BCD_W +: BCD_W])) begin
        ops_valid = 1'b0;
      end
    end
  end

  // The complement pass reuses the same digit slice as 0 - diff_i - borrow.
  always_comb begin
    sub_x = (state_q == CMP) ? '0 : a_q[idx_q*BCD_W +: BCD_W];
    sub_y = (state_q == CMP) ? diff_q[idx_q*BCD_W +: BCD_W] : b_q[idx_q*BCD_W +: BCD_W];
  end

  bcd_digit_sub u_digit (
    .x    (sub_x),
    .y    (sub_y),
    .bin  (borrow_q),
    .d    (sub_d),
    .bout (sub_bout)
  );

  assign last = (idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    idx_d     = idx_q;
    borrow_d  = borrow_q;
    neg_d     = neg_q;
    invalid_d = invalid_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          idx_d     = '0;
          borrow_d  = 1'b0;
          diff_d    = '0;
          neg_d     = 1'b0;
          invalid_d = 1'b0;
          state_d   = SUB;
        end
      end

      SUB: begin
        // Operands are stable while busy, so checking on the first SUB edge suffices.
        if (!ops_valid) begin
          invalid_d = 1'b1;
          diff_d    = '0;
          neg_d     = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          diff_d[idx_q*BCD_W +: BCD_W] = sub_d;
          borrow_d = sub_bout;
          idx_d    = idx_q + 1'b1;
          if (last) begin
            idx_d    = '0;
            borrow_d = 1'b0;
            if (sub_bout) begin
              neg_d   = 1'b1;
              state_d = CMP;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end

      CMP: begin
        diff_d[idx_q*BCD_W +: BCD_W] = sub_d;
        borrow_d = sub_bout;
        idx_d    = idx_q + 1'b1;
        if (last) begin
          idx_d    = '0;
          borrow_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      idx_q     <= '0;
      borrow_q  <= 1'b0;
      neg_q     <= 1'b0;
      invalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      diff_q    <= diff_d;
      idx_q     <= idx_d;
      borrow_q  <= borrow_d;
      neg_q     <= neg_d;
      invalid_q <= invalid_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign diff    = diff_q;
  assign neg     = neg_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Self-checking bench for bcd_sub_serial (NDIG=4) using an expected-result queue
// filled from a decimal reference model when each operation is launched.
module tb_bcd_sub_serial;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  typedef struct {
    logic [W-1:0] diff;
    logic         neg;
    logic         inv;
    int           lat;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         neg;
  logic         invalid;

  exp_t sb[$];
  int   checks;
  int   failures;

  bcd_sub_serial #(.NDIG(NDIG)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .neg     (neg),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: decode both operands, take |A-B|, re-encode as BCD.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   ai, bi, mag, scale;
    logic bad;
    logic [3:0] da, db;
    ai = 0; bi = 0; scale = 1; bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      da = av[i*4 +: 4];
      db = bv[i*4 +: 4];
      if (da > 4'd9 || db > 4'd9) bad = 1'b1;
      ai = ai + int'(da) * scale;
      bi = bi + int'(db) * scale;
      scale = scale * 10;
    end
    e.diff = '0;
    if (bad) begin
      e.neg = 1'b0;
      e.inv = 1'b1;
      e.lat = 1;
    end else begin
      e.inv = 1'b0;
      e.neg = (ai < bi);
      mag   = e.neg ? (bi - ai) : (ai - bi);
      for (int i = 0; i < NDIG; i++) begin
        e.diff[i*4 +: 4] = 4'(mag % 10);
        mag = mag / 10;
      end
      e.lat = e.neg ? 2 * NDIG : NDIG;
    end
    return e;
  endfunction

  // Drives start with the operands at a falling edge, records the expectation,
  // lets the accepting edge E0 pass and returns at the falling edge after it.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    sb.push_back(model(av, bv));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges after E0 until done is seen at a falling edge.
  task automatic wait_done(input int already, output int lat, output bit ok);
    ok  = 1'b0;
    lat = -1;
    for (int cnt = already + 1; cnt <= 40; cnt++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cnt;
        ok  = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    checks++;
    if ({busy, done, diff, neg, invalid} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b diff=%h neg=%b inv=%b exp all zero",
               busy, done, diff, neg, invalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, diff, neg, invalid} !== '0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got busy=%b done=%b diff=%h exp all zero", busy, done, diff);
    end
  endtask

  task automatic test_arith();
    logic [W-1:0] ta[6];
    logic [W-1:0] tb[6];
    exp_t e;
    int   lat;
    bit   ok;
    ta = '{16'h5432, 16'h1234, 16'h0000, 16'h1000, 16'h7777, 16'h0001};
    tb = '{16'h1234, 16'h5432, 16'h9999, 16'h0001, 16'h7777, 16'h0010};
    for (int k = 0; k < 6; k++) begin
      launch(ta[k], tb[k]);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL arith_busy[%0d] got=%b exp=1", k, busy);
      end
      wait_done(0, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != e.lat) begin
        failures++;
        $display("[TB] FAIL arith_latency[%0d] got=%0d exp=%0d", k, lat, e.lat);
      end
      checks++;
      if (diff !== e.diff || neg !== e.neg || invalid !== e.inv) begin
        failures++;
        $display("[TB] FAIL arith_result[%0d] a=%h b=%h got diff=%h neg=%b inv=%b exp diff=%h neg=%b inv=%b",
                 k, ta[k], tb[k], diff, neg, invalid, e.diff, e.neg, e.inv);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== e.diff) begin
        failures++;
        $display("[TB] FAIL arith_after_done[%0d] got done=%b busy=%b diff=%h exp done=0 busy=0 diff=%h",
                 k, done, busy, diff, e.diff);
      end
    end
  endtask

  task automatic test_invalid();
    exp_t e;
    int   lat;
    bit   ok;
    launch(16'h12A4, 16'h0001);
    wait_done(0, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.lat) begin
      failures++;
      $display("[TB] FAIL invalid_latency got=%0d exp=%0d", lat, e.lat);
    end
    checks++;
    if (invalid !== 1'b1 || diff !== e.diff || neg !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL invalid_result got inv=%b diff=%h neg=%b busy=%b exp inv=1 diff=0 neg=0 busy=0",
               invalid, diff, neg, busy);
    end
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    int   lat;
    bit   ok;
    launch(16'h1234, 16'h5432);
    @(posedge clk);
    @(negedge clk);
    a = 16'h9999;
    b = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(2, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.lat) begin
      failures++;
      $display("[TB] FAIL busy_start_latency got=%0d exp=%0d", lat, e.lat);
    end
    checks++;
    if (diff !== e.diff || neg !== e.neg) begin
      failures++;
      $display("[TB] FAIL busy_start_result got diff=%h neg=%b exp diff=%h neg=%b", diff, neg, e.diff, e.neg);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL busy_start_idle got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    bit   ok;
    @(negedge clk);
    a = 16'h5432;
    b = 16'h1234;
    start = 1'b1;
    sb.push_back(model(16'h5432, 16'h1234));
    @(posedge clk);
    wait_done(0, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.lat || diff !== e.diff || neg !== e.neg) begin
      failures++;
      $display("[TB] FAIL b2b_first got lat=%0d diff=%h neg=%b exp lat=%0d diff=%h neg=%b",
               lat, diff, neg, e.lat, e.diff, e.neg);
    end
    a = 16'h0050;
    b = 16'h0100;
    sb.push_back(model(16'h0050, 16'h0100));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_restart got busy=%b exp=1", busy);
    end
    wait_done(0, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.lat || diff !== e.diff || neg !== e.neg) begin
      failures++;
      $display("[TB] FAIL b2b_second got lat=%0d diff=%h neg=%b exp lat=%0d diff=%h neg=%b",
               lat, diff, neg, e.lat, e.diff, e.neg);
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    int   lat;
    bit   ok;
    bit   saw_done;
    launch(16'h1234, 16'h5432);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    void'(sb.pop_front());
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, neg, invalid} !== '0) begin
      failures++;
      $display("[TB] FAIL midop_reset got busy=%b done=%b diff=%h neg=%b inv=%b exp all zero",
               busy, done, diff, neg, invalid);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("[TB] FAIL midop_no_done got done pulse exp none");
    end
    launch(16'h0050, 16'h0100);
    wait_done(0, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.lat || diff !== e.diff || neg !== e.neg || invalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midop_fresh got lat=%0d diff=%h neg=%b inv=%b exp lat=%0d diff=%h neg=%b inv=0",
               lat, diff, neg, invalid, e.lat, e.diff, e.neg);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_arith();
    test_invalid();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_sub_serial.md
Name: bcd_sub_serial

Overview:
- Multi-digit packed-BCD subtractor; the subtract direction of the team's BCD adder path.
- Digit-serial: one BCD digit per clock, least-significant digit first.
- Returns magnitude |a-b| in BCD plus a sign flag. A negative difference is turned back into a magnitude by a second ten's-complement pass.
- Sits beside the BCD adder in the decimal arithmetic datapath. Start/busy/done handshake toward a controller.

Parameters:
- NDIG, 4, number of BCD digits per operand (NDIG >= 1).

Ports:
- clk, input, 1, the single clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request pulse; sampled only in IDLE.
- a, input, 4*NDIG, minuend, packed BCD, digit 0 = bits [3:0].
- b, input, 4*NDIG, subtrahend, packed BCD.
- busy, output, 1, high while an operation is in progress.
- done, output, 1, one-cycle completion pulse.
- diff, output, 4*NDIG, magnitude |a-b| in packed BCD.
- neg, output, 1, 1 when a < b.
- invalid, output, 1, 1 when any digit of a or b was > 9 at start.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, diff=0, neg=0, invalid=0; internal operand registers, digit index and borrow cleared.
  - Reset mid-operation aborts immediately. No done pulse is produced.
- States: IDLE, SUB, CMP.
- IDLE, start=1 at edge E0:
  - Latch a and b.
  - Clear index, borrow, diff, neg and invalid.
  - Set busy=1.
  - If any digit > 9: go to IDLE at E1 with invalid=1, diff=0, neg=0, done=1 for one cycle, busy=0. No arithmetic is performed.
  - Otherwise go to SUB.
- SUB: each edge processes digit i = index:
  - t = a_i - b_i - borrow.
  - If t < 0: diff_i = t+10, borrow=1. Else diff_i = t, borrow=0.
  - index increments.
  - On the edge processing digit NDIG-1:
    - if the final borrow = 0: done=1, busy=0, go to IDLE (latency NDIG edges after E0);
    - if the final borrow = 1: neg=1, index=0, borrow=0, go to CMP.
- CMP: each edge replaces diff_i with (0 - diff_i - borrow) using the same digit rule. This is the ten's complement, giving the magnitude.
  - On the edge for digit NDIG-1: done=1, busy=0, go to IDLE (total latency 2*NDIG edges after E0).
- done is registered. It is high for exactly the cycle after the completing edge, then 0.
- diff, neg and invalid hold their values until the next accepted start.
- start while busy=1 is ignored. Operands are not re-latched.
- start held high in IDLE after done starts a new operation on the next edge.
- Width rules:
  - Digits are handled as 4-bit unsigned values with a 5-bit signed intermediate.
  - The correction +10 is applied modulo 16.
  - The borrow out of the top digit is never written into diff.
- a == b gives diff=0, neg=0, latency NDIG.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W = 4 and BCD_MAX = 9;
  - the state enum (IDLE/SUB/CMP);
  - a digit-valid function (digit <= 9).
- One sub-module, bcd_digit_sub: combinational; inputs x[3:0], y[3:0], bin; outputs d[3:0], bout.
  - Used by both SUB (x=a_i, y=b_i) and CMP (x=0, y=diff_i) through an operand mux.
- The top holds the FSM, index counter, borrow flop and operand/result registers.

Test Plan (NDIG=4):
- a=0x5432, b=0x1234, pulse start -> done 4 edges after E0; diff=0x4198, neg=0, invalid=0.
- a=0x1234, b=0x5432 -> done 8 edges after E0; diff=0x4198, neg=1. Also a=0x0000, b=0x9999 -> diff=0x9999, neg=1.
- Borrow chain: a=0x1000, b=0x0001 -> diff=0x0999, neg=0. Also a=0x7777, b=0x7777 -> diff=0x0000, neg=0, latency 4.
- Invalid: a=0x12A4, b=0x0001 -> done 1 edge after E0; invalid=1, diff=0, neg=0, busy low again.
- Start while busy: second start with different operands at E2 is ignored, first result unchanged. Back-to-back start held high -> second operation begins the edge after done.
- Reset mid-op: deassert rst_n during CMP -> all outputs 0 immediately, no done. Then a fresh op 0x0050-0x0100 -> diff=0x0050, neg=1.
